ram_host_bridge: RTL and testbench

Host-side initiator for the scalar-multiplier operand RAM's host port. It turns a narrow 32-bit command/stream interface into full-width accesses on the RAM's host port:
- assembles 8 write beats into one 256-bit word write;
- reads one 256-bit word and streams it back as 8 beats;
- writes the 4-bit engine command and waits for the engine to clear it.

It sits between the external bus/UART front end and the RAM interface, and is the only driver of the host port.

---
 rtl/ram_host_bridge_pkg.sv | 21 ++
 rtl/ram_host_bridge_beat_shifter.sv | 24 ++
 rtl/ram_host_bridge.sv | 159 +++++++++++++++
 tb/tb_ram_host_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_host_bridge_pkg.sv
// Shared encodings and state type for the RAM host-port bridge.
package ram_host_bridge_pkg;

  localparam logic [1:0] OP_WR    = 2'b00;
  localparam logic [1:0] OP_RD    = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;

  localparam logic [5:0] CMD_ADDR = 6'b000001;

  localparam logic [2:0] BANK_MIN = 3'd1;
  localparam logic [2:0] BANK_MAX = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RADDR, S_RCAP, S_SEND, S_CMD, S_WAIT
  } state_t;

  function automatic logic bank_ok(input logic [2:0] bank);
    return (bank >= BANK_MIN) && (bank <= BANK_MAX);
  endfunction

endpackage

// File: rtl/ram_host_bridge_beat_shifter.sv
// Word-wide register: parallel load, beat shift-in at the top, beat shift-out toward the bottom.
module ram_host_bridge_beat_shifter #(
  parameter int DATA = 256,
  parameter int BEAT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            shift_in,
  input  logic            shift_out,
  input  logic [DATA-1:0] din,
  input  logic [BEAT-1:0] beat_in,
  output logic [DATA-1:0] q
);

  // Shift-in enters at the top so the first beat ends up least significant after DATA/BEAT beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         q <= '0;
    else if (load)      q <= din;
    else if (shift_in)  q <= {beat_in, q[DATA-1:BEAT]};
    else if (shift_out) q <= {{BEAT{1'b0}}, q[DATA-1:BEAT]};
  end

endmodule

// File: rtl/ram_host_bridge.sv
// Bridges a 32-bit command/beat stream to the full-width operand RAM host port.
module ram_host_bridge #(
  parameter int DATA    = 256,
  parameter int BEAT    = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [5:0]      cmd_addr,
  input  logic [3:0]      cmd_code,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [BEAT-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [BEAT-1:0] rd_data,
  output logic            ram_w,
  output logic [5:0]      ram_adbus,
  output logic [DATA-1:0] ram_wdata,
  input  logic [DATA-1:0] ram_rdata,
  input  logic [3:0]      ram_command,
  output logic            done,
  output logic            err
);
  import ram_host_bridge_pkg::*;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t          state;
  logic [5:0]      addr_q;
  logic [2:0]      beat_cnt;
  logic [15:0]     wait_cnt;
  logic            accept, beat_in_fire, beat_out_fire, sh_load;
  logic [DATA-1:0] sh_din, sh_q;

  assign accept        = cmd_valid && cmd_ready;
  assign beat_in_fire  = wr_valid && wr_ready;
  assign beat_out_fire = rd_valid && rd_ready;

  // The command code rides through the shifter so CMD drives it on ram_wdata like any word.
  assign sh_load = (state == S_RCAP) || (accept && cmd_op == OP_START);
  assign sh_din  = (state == S_RCAP) ? ram_rdata : DATA'(cmd_code);

  ram_host_bridge_beat_shifter #(.DATA(DATA), .BEAT(BEAT)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .shift_in  (beat_in_fire),
    .shift_out (beat_out_fire),
    .din       (sh_din),
    .beat_in   (wr_data),
    .q         (sh_q)
  );

  assign ram_wdata = sh_q;
  assign rd_data   = sh_q[BEAT-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      ram_w     <= 1'b0;
      ram_adbus <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      addr_q    <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          addr_q   <= cmd_addr;
          beat_cnt <= '0;
          case (cmd_op)
            OP_WR, OP_RD: begin
              if (!bank_ok(cmd_addr[5:3])) begin
                err <= 1'b1;
              end else if (cmd_op == OP_WR) begin
                state     <= S_LOAD;
                cmd_ready <= 1'b0;
                wr_ready  <= 1'b1;
              end else begin
                state     <= S_RADDR;
                cmd_ready <= 1'b0;
                ram_adbus <= cmd_addr;
              end
            end
            OP_START: begin
              state     <= S_CMD;
              cmd_ready <= 1'b0;
              ram_w     <= 1'b1;
              ram_adbus <= CMD_ADDR;
            end
            default: err <= 1'b1;
          endcase
        end
        S_LOAD: if (beat_in_fire) begin
          beat_cnt <= beat_cnt + 3'd1;
          if (beat_cnt == 3'd7) begin
            state     <= S_WRITE;
            wr_ready  <= 1'b0;
            ram_w     <= 1'b1;
            ram_adbus <= addr_q;
          end
        end
        S_WRITE: begin
          state     <= S_IDLE;
          ram_w     <= 1'b0;
          ram_adbus <= '0;
          done      <= 1'b1;
          cmd_ready <= 1'b1;
        end
        S_RADDR: state <= S_RCAP;
        S_RCAP: begin
          state     <= S_SEND;
          rd_valid  <= 1'b1;
          ram_adbus <= '0;
        end
        S_SEND: if (beat_out_fire) begin
          beat_cnt <= beat_cnt + 3'd1;
          if (beat_cnt == 3'd7) begin
            state     <= S_IDLE;
            rd_valid  <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        S_CMD: begin
          state     <= S_WAIT;
          ram_w     <= 1'b0;
          ram_adbus <= '0;
          wait_cnt  <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          // Cycle 0 still sees the echo of the command just written.
          if (wait_cnt != 16'd0 && ram_command == 4'd0) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= S_IDLE;
            err       <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_host_bridge.sv
// Randomized self-checking bench for ram_host_bridge against a word/beat level reference.
module tb_ram_host_bridge;
  localparam int DATA = 256;
  localparam int BEAT = 32;
  localparam int TO   = 20;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [5:0]      cmd_addr = '0;
  logic [3:0]      cmd_code = '0;
  logic            wr_valid = 1'b0, wr_ready;
  logic [BEAT-1:0] wr_data = '0;
  logic            rd_valid, rd_ready = 1'b0;
  logic [BEAT-1:0] rd_data;
  logic            ram_w;
  logic [5:0]      ram_adbus;
  logic [DATA-1:0] ram_wdata;
  logic [DATA-1:0] ram_rdata = '0;
  logic [3:0]      ram_command = '0;
  logic            done, err;

  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  ram_host_bridge #(.DATA(DATA), .BEAT(BEAT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_code(cmd_code),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_w(ram_w), .ram_adbus(ram_adbus), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_command(ram_command),
    .done(done), .err(err)
  );

  // RAM host port: one-cycle read latency, only rd_addr holds rd_word; writes are logged.
  logic [5:0]      rd_addr = '0;
  logic [DATA-1:0] rd_word = '0;
  int              w_cnt = 0;
  logic [5:0]      w_addr = '0;
  logic [DATA-1:0] w_data = '0;
  int              both = 0;

  always @(posedge clk) begin
    ram_rdata <= (ram_adbus == rd_addr) ? rd_word : '0;
    if (ram_w) begin
      w_cnt  <= w_cnt + 1;
      w_addr <= ram_adbus;
      w_data <= ram_wdata;
    end
  end

  always @(negedge clk) if (done && err) both <= both + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [5:0] rand_valid_addr();
    return {3'($urandom_range(1, 4)), 3'($urandom)};
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [3:0] code);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_code = code;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 6'($urandom); cmd_code = 4'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, ram_w, done, err, ram_adbus} !== 12'h800) begin
      fails++;
      $display("FAIL reset_ctrl: got %h want 800",
               {cmd_ready, wr_ready, rd_valid, ram_w, done, err, ram_adbus});
    end
    checks++;
    if (ram_wdata !== '0 || rd_data !== '0) begin
      fails++; $display("FAIL reset_data: wdata %h rd_data %h want 0", ram_wdata, rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write(input logic [5:0] addr, input bit seq, input bit stall);
    logic [BEAT-1:0] beats [8];
    logic [DATA-1:0] exp = '0;
    int k = 0, cyc = 0, w0;
    logic fire;
    for (int i = 0; i < 8; i++) begin
      beats[i] = seq ? BEAT'(i) : BEAT'($urandom);
      exp = exp | (DATA'(beats[i]) << (BEAT * i));
    end
    w0 = w_cnt;
    send_cmd(2'b00, addr, 4'h0);
    while (k < 8 && cyc < 100) begin
      fire = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_valid = fire;
      wr_data  = fire ? beats[k] : BEAT'($urandom);
      fire = fire && wr_ready;
      @(negedge clk); cyc++;
      if (fire) k++;
    end
    wr_valid = 1'b0;
    checks++;
    if (k != 8) begin fails++; $display("FAIL write_beats: accepted %0d want 8", k); end
    checks++;
    if (ram_w !== 1'b1 || ram_adbus !== addr || cmd_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL write_strobe: w %b adbus %h rdy %b done %b want 1 %h 0 0",
               ram_w, ram_adbus, cmd_ready, done, addr);
    end
    checks++;
    if (ram_wdata !== exp) begin
      fails++; $display("FAIL write_data: got %h want %h", ram_wdata, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ram_w !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL write_done: done %b w %b rdy %b err %b want 1 0 1 0", done, ram_w, cmd_ready, err);
    end
    checks++;
    if (w_cnt - w0 != 1 || w_data !== exp || w_addr !== addr) begin
      fails++;
      $display("FAIL write_ram: writes %0d addr %h want 1 %h", w_cnt - w0, w_addr, addr);
    end
  endtask

  task automatic test_read(input logic [5:0] addr, input logic [DATA-1:0] word, input bit stall);
    int k = 0, cyc = 0, w0;
    logic r;
    logic [BEAT-1:0] exp_beat;
    rd_addr = addr; rd_word = word; w0 = w_cnt;
    send_cmd(2'b01, addr, 4'h0);
    checks++;
    if (ram_adbus !== addr || ram_w !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL read_raddr: adbus %h w %b rv %b rdy %b want %h 0 0 0",
               ram_adbus, ram_w, rd_valid, cmd_ready, addr);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL read_rcap: rd_valid %b want 0", rd_valid); end
    @(negedge clk);
    while (k < 8 && cyc < 100) begin
      exp_beat = BEAT'(word >> (BEAT * k));
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_beat) begin
        fails++;
        $display("FAIL read_beat%0d: valid %b data %h want 1 %h", k, rd_valid, rd_data, exp_beat);
      end
      r = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      rd_ready = r;
      @(negedge clk); cyc++;
      if (r) k++;
    end
    rd_ready = 1'b0;
    checks++;
    if (k != 8 || done !== 1'b1 || rd_valid !== 1'b0 || cmd_ready !== 1'b1 || w_cnt != w0) begin
      fails++;
      $display("FAIL read_done: beats %0d done %b rv %b rdy %b writes %0d want 8 1 0 1 0",
               k, done, rd_valid, cmd_ready, w_cnt - w0);
    end
  endtask

  task automatic test_start(input int h, input logic [3:0] code);
    int jstar = (h < 1) ? 1 : h;
    send_cmd(2'b10, 6'($urandom), code);
    checks++;
    if (ram_w !== 1'b1 || ram_adbus !== 6'd1 || ram_wdata !== DATA'(code)) begin
      fails++;
      $display("FAIL start_cmd: w %b adbus %h wdata %h want 1 01 %h", ram_w, ram_adbus, ram_wdata, code);
    end
    ram_command = code;
    for (int n = 1; n <= jstar + 2; n++) begin
      @(negedge clk);
      ram_command = (n - 1 < h) ? code : 4'd0;
      checks++;
      if (done !== (n == jstar + 2) || err !== 1'b0 || cmd_ready !== (n == jstar + 2) || ram_w !== 1'b0) begin
        fails++;
        $display("FAIL start_wait%0d: done %b err %b rdy %b w %b want %b 0 %b 0",
                 n, done, err, cmd_ready, ram_w, n == jstar + 2, n == jstar + 2);
      end
    end
    ram_command = 4'd0;
  endtask

  task automatic test_timeout;
    send_cmd(2'b10, 6'($urandom), 4'h5);
    ram_command = 4'h5;
    for (int n = 1; n <= TO + 2; n++) begin
      @(negedge clk);
      checks++;
      if (err !== (n == TO + 1) || done !== 1'b0 || (n == TO + 1 && cmd_ready !== 1'b1)) begin
        fails++;
        $display("FAIL timeout_cyc%0d: err %b done %b rdy %b want %b 0", n, err, done, cmd_ready, n == TO + 1);
      end
    end
    ram_command = 4'd0;
  endtask

  task automatic test_reject;
    logic [1:0] ops [5];
    logic [5:0] addrs [5];
    logic exp_err;
    int w0 = w_cnt;
    ops[0] = 2'b00; addrs[0] = {3'd0, 3'($urandom)};
    ops[1] = 2'b01; addrs[1] = {3'($urandom_range(5, 7)), 3'($urandom)};
    ops[2] = 2'b00; addrs[2] = {3'($urandom_range(5, 7)), 3'($urandom)};
    ops[3] = 2'b11; addrs[3] = rand_valid_addr();
    ops[4] = 2'b01; addrs[4] = {3'd0, 3'($urandom)};
    for (int i = 0; i < 5; i++) begin
      exp_err = (ops[i] == 2'b11) || (addrs[i][5:3] < 3'd1) || (addrs[i][5:3] > 3'd4);
      send_cmd(ops[i], addrs[i], 4'($urandom));
      checks++;
      if (err !== exp_err || done !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b0 ||
          rd_valid !== 1'b0 || ram_w !== 1'b0) begin
        fails++;
        $display("FAIL reject%0d: err %b done %b rdy %b wrdy %b rv %b w %b want %b 0 1 0 0 0",
                 i, err, done, cmd_ready, wr_ready, rd_valid, ram_w, exp_err);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || wr_ready !== 1'b0) begin
        fails++; $display("FAIL reject%0d_pulse: err %b wrdy %b want 0 0", i, err, wr_ready);
      end
    end
    checks++;
    if (w_cnt != w0) begin fails++; $display("FAIL reject_ram: writes %0d want 0", w_cnt - w0); end
  endtask

  task automatic test_reset_mid;
    logic [5:0] addr = rand_valid_addr();
    int w0 = w_cnt;
    send_cmd(2'b00, addr, 4'h0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = BEAT'($urandom) | 32'hF000_0000;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, ram_w, done, err, ram_adbus} !== 12'h800 ||
        ram_wdata !== '0 || rd_data !== '0) begin
      fails++;
      $display("FAIL reset_mid: ctrl %h wdata %h want 800 0",
               {cmd_ready, wr_ready, rd_valid, ram_w, done, err, ram_adbus}, ram_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (w_cnt != w0) begin fails++; $display("FAIL reset_mid_ram: writes %0d want 0", w_cnt - w0); end
    test_write(addr, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [DATA-1:0] word;
    for (int i = 0; i < 4; i++) begin
      test_write(rand_valid_addr(), 1'b0, i[0]);
      for (int b = 0; b < 8; b++) word[BEAT*b +: BEAT] = BEAT'($urandom);
      test_read(rand_valid_addr(), word, i[1]);
    end
  endtask

  initial begin
    logic [DATA-1:0] pat;
    logic [DATA-1:0] rnd;
    for (int b = 0; b < 32; b++) pat[8*b +: 8] = 8'(b);
    for (int b = 0; b < 8; b++) rnd[BEAT*b +: BEAT] = BEAT'($urandom);
    test_reset;
    test_write(6'b010_011, 1'b1, 1'b0);
    test_write(rand_valid_addr(), 1'b0, 1'b1);
    test_read(6'b100_010, pat, 1'b0);
    test_read(rand_valid_addr(), rnd, 1'b1);
    test_start(10, 4'h5);
    test_start(0, 4'($urandom_range(1, 15)));
    test_start($urandom_range(2, 15), 4'($urandom_range(1, 15)));
    test_timeout;
    test_reject;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (both != 0) begin fails++; $display("FAIL done_err_overlap: %0d cycles want 0", both); end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
